// File: rtl/usb_tx_serializer.sv
// USB transmit back end: takes bytes from the SIE, sends SYNC, serialises LSB first
// with bit stuffing and NRZI, closes the packet with SE0 SE0 J and drives the pads.
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit LOW_SPEED    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       usb_oe
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic J_DP = LOW_SPEED ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t state, next_state;

    logic [TW-1:0] timer;
    logic [7:0]    shifter;
    logic [2:0]    bit_idx;
    logic [2:0]    ones_cnt;
    logic          line_k;
    logic          se0;
    logic          eop_second;

    logic          strobe;
    logic          stuff_due;
    logic          start_pkt;
    logic          send_stuff;
    logic          advance;
    logic          load_byte;
    logic          eop_enter;
    logic          send_bit;
    logic          next_bit;
    logic [2:0]    nxt_idx;

    assign strobe    = (state != IDLE) && (timer == TIMER_LAST);
    assign stuff_due = (ones_cnt == 3'd6);
    assign nxt_idx   = bit_idx + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A cell boundary either inserts a stuff bit, moves to the next bit, fetches a
    // new byte, or closes the packet; a pending stuff bit always goes out first.
    always_comb begin
        next_state = state;
        start_pkt  = 1'b0;
        send_stuff = 1'b0;
        advance    = 1'b0;
        load_byte  = 1'b0;
        eop_enter  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    next_state = SYNC;
                    start_pkt  = 1'b1;
                end
            end
            SYNC, DATA: begin
                if (strobe) begin
                    if (stuff_due) begin
                        send_stuff = 1'b1;
                    end else if (bit_idx != 3'd7) begin
                        advance = 1'b1;
                    end else if (tx_valid) begin
                        load_byte  = 1'b1;
                        next_state = DATA;
                    end else begin
                        eop_enter  = 1'b1;
                        next_state = EOP_SE0;
                    end
                end
            end
            EOP_SE0: begin
                if (strobe && eop_second) begin
                    next_state = EOP_J;
                end
            end
            EOP_J: begin
                if (strobe) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign send_bit = advance || load_byte;
    assign next_bit = load_byte ? tx_data[0] : shifter[nxt_idx];

    // line_k holds the NRZI line state (0 = J); a data 0 toggles it, a 1 holds it
    // and extends the run of ones that triggers stuffing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer      <= '0;
            shifter    <= '0;
            bit_idx    <= '0;
            ones_cnt   <= '0;
            line_k     <= 1'b0;
            se0        <= 1'b0;
            eop_second <= 1'b0;
        end else begin
            if (state == IDLE || strobe) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (start_pkt) begin
                shifter    <= 8'h80;
                bit_idx    <= 3'd0;
                ones_cnt   <= 3'd0;
                line_k     <= 1'b1;
                se0        <= 1'b0;
                eop_second <= 1'b0;
            end

            if (send_stuff) begin
                line_k   <= ~line_k;
                ones_cnt <= 3'd0;
            end

            if (send_bit) begin
                bit_idx <= load_byte ? 3'd0 : nxt_idx;
                if (next_bit) begin
                    ones_cnt <= ones_cnt + 3'd1;
                end else begin
                    ones_cnt <= 3'd0;
                    line_k   <= ~line_k;
                end
            end

            if (load_byte) begin
                shifter <= tx_data;
            end

            if (eop_enter) begin
                se0        <= 1'b1;
                eop_second <= 1'b0;
            end

            if (state == EOP_SE0 && strobe) begin
                if (!eop_second) begin
                    eop_second <= 1'b1;
                end else begin
                    se0    <= 1'b0;
                    line_k <= 1'b0;
                end
            end
        end
    end

    assign tx_ready  = load_byte;
    assign tx_active = (state != IDLE);
    assign usb_oe    = (state != IDLE);
    assign usb_dp_o  = se0 ? 1'b0 : (line_k ? ~J_DP : J_DP);
    assign usb_dn_o  = se0 ? 1'b0 : (line_k ? J_DP : ~J_DP);

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: checks line symbols per bit cell, tx_ready
// timing and output-enable duration against hand-worked packets.
module tb_usb_tx_serializer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_active;
    logic       usb_dp_o;
    logic       usb_dn_o;
    logic       usb_oe;

    usb_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .LOW_SPEED   (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_active(tx_active),
        .usb_dp_o (usb_dp_o),
        .usb_dn_o (usb_dn_o),
        .usb_oe   (usb_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  pkt_bytes[$];
    logic [63:0] sym_seq;
    int          ready_clks[$];
    int          oe_clks;
    int          first_oe;
    int          act_err;
    logic        oe_at_start;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Symbols packed two bits each as {dp,dn}: J=01, K=10, SE0=00 for low speed
    function automatic logic [63:0] symVec(input string s);
        logic [63:0] v = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "J": v = {v[61:0], 2'b01};
                "K": v = {v[61:0], 2'b10};
                "0": v = {v[61:0], 2'b00};
                default: ;
            endcase
        end
        return v;
    endfunction

    // Plays pkt_bytes as the SIE and records one line sample per bit cell.
    // late_gap: withdraw tx_valid after each accepted byte and re-present the next
    // one only 5 clks before the byte-boundary strobe.
    task automatic applyStimulus(input bit late_gap, input bit raise_in_eop,
                                 input logic [7:0] next_first, input int abort_at);
        int  clk_cnt = 0;
        int  idx = 0;
        int  hold_until = -1;
        bit  seen = 1'b0;
        bit  done = 1'b0;
        sym_seq = '0;
        ready_clks.delete();
        oe_clks = 0;
        first_oe = -1;
        act_err = 0;
        oe_at_start = usb_oe;
        tx_data = pkt_bytes[0];
        tx_valid = 1'b1;
        while (!done && clk_cnt < 3000) begin
            @(negedge clk);
            clk_cnt++;
            if (abort_at > 0 && clk_cnt == abort_at) begin
                reset_n = 1'b0;
                #1;
                checkOutput("abort_oe", {63'd0, usb_oe}, 64'd0);
                checkOutput("abort_active", {63'd0, tx_active}, 64'd0);
                checkOutput("abort_ready", {63'd0, tx_ready}, 64'd0);
                checkOutput("abort_line_j", {62'd0, usb_dp_o, usb_dn_o}, 64'd1);
                tx_valid = 1'b0;
                return;
            end
            if (usb_oe !== tx_active) act_err++;
            if (usb_oe) begin
                if (!seen) first_oe = clk_cnt;
                seen = 1'b1;
                if ((clk_cnt - first_oe) % CPB == CPB / 2)
                    sym_seq = {sym_seq[61:0], usb_dp_o, usb_dn_o};
                oe_clks++;
            end else if (seen) begin
                done = 1'b1;
            end
            if (!done) begin
                if (raise_in_eop && idx >= pkt_bytes.size() && usb_oe && !usb_dp_o && !usb_dn_o) begin
                    tx_data = next_first;
                    tx_valid = 1'b1;
                end
                if (hold_until > 0 && clk_cnt == hold_until) tx_valid = 1'b1;
                if (tx_ready) begin
                    ready_clks.push_back(clk_cnt);
                    @(posedge clk);
                    #1;
                    idx++;
                    if (idx < pkt_bytes.size()) begin
                        tx_data = pkt_bytes[idx];
                        if (late_gap) begin
                            tx_valid = 1'b0;
                            hold_until = clk_cnt + 8 * CPB - 5;
                        end
                    end else begin
                        tx_valid = 1'b0;
                    end
                end
            end
        end
        if (!done) begin
            checkOutput("timeout", 64'd1, 64'd0);
            tx_valid = 1'b0;
        end
    endtask

    task automatic checkPacket(input string name, input string syms, input int n_ready,
                               input int r0, input int r1, input int oe_len);
        checkOutput({name, "_symbols"}, sym_seq, symVec(syms));
        checkOutput({name, "_ready_count"}, 64'(ready_clks.size()), 64'(n_ready));
        if (n_ready > 0 && ready_clks.size() > 0)
            checkOutput({name, "_ready0_clk"}, 64'(ready_clks[0]), 64'(r0));
        if (n_ready > 1 && ready_clks.size() > 1)
            checkOutput({name, "_ready1_clk"}, 64'(ready_clks[1]), 64'(r1));
        checkOutput({name, "_oe_clks"}, 64'(oe_clks), 64'(oe_len));
        checkOutput({name, "_first_oe"}, 64'(first_oe), 64'd1);
        checkOutput({name, "_active_eq_oe"}, 64'(act_err), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_oe", {63'd0, usb_oe}, 64'd0);
        checkOutput("reset_active", {63'd0, tx_active}, 64'd0);
        checkOutput("reset_ready", {63'd0, tx_ready}, 64'd0);
        checkOutput("reset_line_j", {62'd0, usb_dp_o, usb_dn_o}, 64'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        pkt_bytes = '{8'hD2};
        applyStimulus(1'b0, 1'b0, 8'h00, 0);
        checkPacket("ack", "KJKJKJKK JJKJJKKK 00J", 1, 128, 0, 304);
        checkOutput("idle_line_j", {62'd0, usb_dp_o, usb_dn_o}, 64'd1);
        repeat (4) @(negedge clk);

        pkt_bytes = '{8'hFF, 8'hFF};
        applyStimulus(1'b0, 1'b0, 8'h00, 0);
        checkPacket("stuff", "KJKJKJKK KKKKKJJJJ JJJKKKKKK 00J", 2, 128, 272, 464);
        repeat (4) @(negedge clk);

        pkt_bytes = '{8'hFC};
        applyStimulus(1'b0, 1'b0, 8'h00, 0);
        checkPacket("stuff_end", "KJKJKJKK JKKKKKKKJ 00J", 1, 128, 0, 320);
        repeat (4) @(negedge clk);

        pkt_bytes = '{8'hA5, 8'h3C};
        applyStimulus(1'b1, 1'b0, 8'h00, 0);
        checkPacket("backpressure", "KJKJKJKK KJJKJJKK JKKKKKJK 00J", 2, 128, 256, 432);
        repeat (4) @(negedge clk);

        pkt_bytes = '{8'h00, 8'h00, 8'h00};
        applyStimulus(1'b0, 1'b0, 8'h00, 200);
        checkOutput("abort_ready_count", 64'(ready_clks.size()), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        pkt_bytes = '{8'hD2};
        applyStimulus(1'b0, 1'b0, 8'h00, 0);
        checkPacket("after_abort", "KJKJKJKK JJKJJKKK 00J", 1, 128, 0, 304);
        repeat (4) @(negedge clk);

        pkt_bytes = '{8'hD2};
        applyStimulus(1'b0, 1'b1, 8'hD2, 0);
        checkOutput("b2b_p1_ready_count", 64'(ready_clks.size()), 64'd1);
        pkt_bytes = '{8'hD2};
        applyStimulus(1'b0, 1'b0, 8'h00, 0);
        checkOutput("b2b_idle_gap", {63'd0, oe_at_start}, 64'd0);
        checkPacket("b2b_p2", "KJKJKJKK JJKJJKKK 00J", 1, 128, 0, 304);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
